bsg_fifo_yumi_serializer: RTL

// Drain-side companion to the 1r1w small FIFO: consumes whole words from a

---
 rtl/bsg_fifo_yumi_serializer.sv | 91 +++++++++
 1 files changed

// File: rtl/bsg_fifo_yumi_serializer.sv
// Drains whole words from a valid-yumi FIFO and replays them as narrow
// valid-ready chunks, LSB chunk first, with a per-word chunk count.
module bsg_fifo_yumi_serializer
  #(parameter int chunk_width_p = 32
  , parameter int chunks_p      = 16
  , localparam int len_width_lp  = (chunks_p > 1) ? $clog2(chunks_p) : 1
  , localparam int data_width_lp = chunk_width_p * chunks_p
  )
  ( input  logic                     clk_i
  , input  logic                     reset_i
  , input  logic                     v_i
  , input  logic [data_width_lp-1:0] data_i
  , input  logic [len_width_lp-1:0]  len_i
  , output logic                     yumi_o
  , output logic                     v_o
  , output logic [chunk_width_p-1:0] data_o
  , output logic                     last_o
  , input  logic                     ready_i
  );

  typedef enum logic [0:0] {IDLE = 1'b0, SEND = 1'b1} state_e;

  state_e                    state_r;
  state_e                    state_n_s;
  logic [data_width_lp-1:0]  shift_r;
  logic [len_width_lp-1:0]   len_r;
  logic [len_width_lp-1:0]   cnt_r;
  logic                      xfer_s;

  // State register
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_n_s;
    end
  end

  // Next-state logic: a last-chunk transfer either reloads or returns to IDLE
  always_comb begin
    state_n_s = state_r;
    case (state_r)
      IDLE: begin
        if (yumi_o) begin
          state_n_s = SEND;
        end else begin
          state_n_s = IDLE;
        end
      end
      SEND: begin
        if (xfer_s && last_o) begin
          state_n_s = yumi_o ? SEND : IDLE;
        end else begin
          state_n_s = SEND;
        end
      end
      default: state_n_s = IDLE;
    endcase
  end

  // Output logic; yumi_o may take the next word in the same cycle the last chunk leaves
  always_comb begin
    v_o    = (state_r == SEND);
    last_o = v_o & (cnt_r == len_r);
    xfer_s = v_o & ready_i;
    data_o = shift_r[chunk_width_p-1:0];
    yumi_o = v_i & ~reset_i & ((state_r == IDLE) | (xfer_s & last_o));
  end

  // Word datapath: load on yumi, shift toward the LSB on each non-last transfer
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      shift_r <= '0;
      len_r   <= '0;
      cnt_r   <= '0;
    end else if (yumi_o) begin
      shift_r <= data_i;
      len_r   <= len_i;
      cnt_r   <= '0;
    end else if (xfer_s && !last_o) begin
      shift_r <= shift_r >> chunk_width_p;
      len_r   <= len_r;
      cnt_r   <= cnt_r + len_width_lp'(1);
    end else begin
      shift_r <= shift_r;
      len_r   <= len_r;
      cnt_r   <= cnt_r;
    end
  end

endmodule
